fixed_multiplier_seq: RTL and testbench
=======================================

Name: fixed_multiplier_seq

Overview:
Parametrised, sequential signed fixed-point multiplier. It is the successor to the combinational Q16.16 multiplier in the fixed-point ALU.
- Operand width and fraction bits are generic.
- Rounding and saturation are run-time selectable.
- Valid/ready handshakes on input and output.
- Iterative radix-2 shift-add core: one multiplier bit per cycle, trading latency for area in the calculator datapath.

Parameters:
WIDTH, 32, total operand/result width in bits (two's complement), minimum 4
FRAC, 16, fractional bits of operands and result (QI.F with I=WIDTH-FRAC), 0 <= FRAC < WIDTH

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  operands present
in_ready  out  1  block can accept operands
a  in  WIDTH  multiplicand, signed fixed-point
b  in  WIDTH  multiplier, signed fixed-point
round_mode  in  1  0 = truncate toward -inf; 1 = round half up (add 2^(FRAC-1) before shift)
sat_en  in  1  1 = clamp on overflow; 0 = wrap (low WIDTH bits)
out_valid  out  1  result available
out_ready  in  1  consumer takes result
result  out  WIDTH  signed fixed-point product
overflow  out  1  true result not representable in WIDTH bits; valid with out_valid
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: rst_n low at a clk edge forces IDLE from any state, including mid-CALC; the in-flight operation is discarded. Registered outputs reset to: in_ready=1, out_valid=0, result=0, overflow=0, busy=0.
- States (encoded in the package):
  - IDLE: in_ready=1. On in_valid&in_ready, capture a, b, round_mode and sat_en, then go to CALC with count=0. Later input changes are ignored.
  - CALC: WIDTH cycles. Each cycle: if multiplier-magnitude bit[count] is 1, add the shifted multiplicand magnitude into the 2*WIDTH-bit unsigned accumulator; count++. After count=WIDTH-1, go to NORM.
  - NORM: one cycle. Combinational round/saturate (see below) is registered into result/overflow; out_valid<=1; go to DONE.
  - DONE: out_valid=1; result and overflow held stable. On out_ready, out_valid<=0 and go to IDLE. in_ready stays 0 here, so results never overlap.
- Latency: accept edge E0. out_valid is high after edge E(WIDTH+1), i.e. 34 edges for WIDTH=32. Minimum initiation interval is WIDTH+3 cycles with out_ready tied high.
- Arithmetic:
  - Magnitudes |a| and |b| are WIDTH-bit unsigned. -2^(WIDTH-1) maps to 2^(WIDTH-1) with no overflow.
  - Sign = a[MSB]^b[MSB]; a zero magnitude product forces sign positive.
  - The signed product P (2*WIDTH+1 bits) is formed in NORM.
  - If round_mode=1 and FRAC>0, P += 2^(FRAC-1). Then arithmetic shift right by FRAC.
  - overflow=1 iff the shifted value lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - On overflow with sat_en=1: result = 2^(WIDTH-1)-1 (positive) or -2^(WIDTH-1) (negative).
  - On overflow with sat_en=0: result = low WIDTH bits of the shifted value.
  - With no overflow, result is the shifted value. overflow is reported regardless of sat_en.
- With WIDTH=32, FRAC=16, round_mode=0, sat_en=0, result and overflow are bit-identical to the existing combinational multiplier.
- in_valid while not in IDLE: ignored, no capture. out_ready outside DONE: ignored.

Decomposition:
- Shared package fixed_pkg holds:
  - state enum (IDLE, CALC, NORM, DONE)
  - round-mode constants ROUND_TRUNC=0, ROUND_HALF_UP=1
  - helper constants for max/min signed values as functions of WIDTH
- One natural combinational sub-module, fixed_round_sat (params WIDTH, FRAC):
  - inputs: sign, 2*WIDTH-bit magnitude, round_mode, sat_en
  - outputs: result, overflow
  - reused later by the divider.

Test Plan:
1. Basic: a=0x00018000 (1.5), b=0x00020000 (2.0), mode 0, sat 0. Expect result=0x00030000, overflow=0, out_valid exactly 34 edges after accept; a=0xFFFE8000 (-1.5) gives 0xFFFD0000.
2. Overflow: a=0x7FFF0000, b=0x00020000. With sat_en=1 expect 0x7FFFFFFF, overflow=1; with sat_en=0 expect 0xFFFE0000, overflow=1. Also a=b=0x80000000, sat_en=1: expect 0x7FFFFFFF, overflow=1.
3. Rounding: a=0x00000001, b=0x00008000. Mode 0 gives 0x00000000; mode 1 gives 0x00000001. For a=0xFFFFFFFF, mode 0 gives 0xFFFFFFFF; mode 1 gives 0x00000000. overflow=0 in all four.
4. Handshake:
   - Hold out_ready=0 for 5 cycles after out_valid: result stable, in_ready=0.
   - Pulse in_valid with new operands during CALC: not captured.
   - Then out_ready=1: next cycle in_ready=1.
5. Reset mid-operation: assert rst_n=0 for one edge at count=10 of CALC. Expect IDLE, in_ready=1, out_valid=0, result=0. A subsequent 1.5*2.0 gives 0x00030000.
6. Parameter sweep: WIDTH=8, FRAC=4, random signed operands and all mode combinations. Scoreboard against a behavioural model; check latency = WIDTH+2 edges from accept to out_valid.

Source files
------------

// File: rtl/fixed_pkg.sv
// Shared definitions for the fixed-point arithmetic blocks: the sequencer state
// encoding, the rounding-mode codes and the signed saturation limits.
package fixed_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic ROUND_TRUNC   = 1'b0;
    localparam logic ROUND_HALF_UP = 1'b1;

    // The limits are built in a wide container and sliced to WIDTH by the user.
    localparam int MAX_WIDTH = 128;

    function automatic logic [MAX_WIDTH-1:0] max_signed(input int width);
        logic [MAX_WIDTH-1:0] one;
        one = {{(MAX_WIDTH-1){1'b0}}, 1'b1};
        return (one << (width - 1)) - one;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] min_signed(input int width);
        logic [MAX_WIDTH-1:0] one;
        one = {{(MAX_WIDTH-1){1'b0}}, 1'b1};
        return one << (width - 1);
    endfunction

endpackage

// File: rtl/fixed_round_sat.sv
// Turns a sign plus a double-width product magnitude into a WIDTH-bit signed
// fixed-point result, with optional half-up rounding and saturation on overflow.
module fixed_round_sat
    import fixed_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic               sign,
    input  logic [2*WIDTH-1:0] mag,
    input  logic               round_mode,
    input  logic               sat_en,
    output logic [WIDTH-1:0]   result,
    output logic               overflow
);

    localparam int PW = 2*WIDTH + 1;
    localparam logic [MAX_WIDTH-1:0] MAX_FULL = max_signed(WIDTH);
    localparam logic [MAX_WIDTH-1:0] MIN_FULL = min_signed(WIDTH);
    localparam logic [WIDTH-1:0] MAX_VAL = MAX_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MIN_VAL = MIN_FULL[WIDTH-1:0];
    localparam int HALF_SHIFT = (FRAC > 0) ? FRAC - 1 : 0;
    localparam logic [PW-1:0] HALF = (FRAC > 0) ? (PW'(1) << HALF_SHIFT) : '0;

    logic                 neg;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] rounded;
    logic signed [PW-1:0] shifted;
    logic [WIDTH+1:0]     upper;

    // A zero magnitude is always treated as positive so that -0 never appears.
    // The value fits in WIDTH bits exactly when everything from bit WIDTH-1 up
    // is a copy of the sign.
    always_comb begin
        neg      = sign && (mag != '0);
        prod     = neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
        rounded  = (round_mode == ROUND_HALF_UP) ? prod + $signed(HALF) : prod;
        shifted  = rounded >>> FRAC;
        upper    = shifted[PW-1:WIDTH-1];
        overflow = !((&upper) || (upper == '0));
        if (overflow && sat_en) begin
            result = shifted[PW-1] ? MIN_VAL : MAX_VAL;
        end else begin
            result = shifted[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fixed_multiplier_seq.sv
// Sequential signed fixed-point multiplier: radix-2 shift-add over operand
// magnitudes, one multiplier bit per cycle, with valid/ready on both sides.
module fixed_multiplier_seq
    import fixed_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             round_mode,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic               sign_q;
    logic               round_q;
    logic               sat_q;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   rs_result;
    logic               rs_overflow;

    // The most negative operand negates to itself, which read as unsigned is
    // exactly its magnitude.
    always_comb begin
        a_mag = a[WIDTH-1] ? -a : a;
        b_mag = b[WIDTH-1] ? -b : b;
    end

    fixed_round_sat #(
        .WIDTH(WIDTH),
        .FRAC (FRAC)
    ) u_round_sat (
        .sign      (sign_q),
        .mag       (acc),
        .round_mode(round_q),
        .sat_en    (sat_q),
        .result    (rs_result),
        .overflow  (rs_overflow)
    );

    // The multiplicand shifts left and the multiplier right each CALC cycle, so
    // mplier[0] is always the bit selected by count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            sign_q    <= 1'b0;
            round_q   <= ROUND_TRUNC;
            sat_q     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= {{WIDTH{1'b0}}, a_mag};
                        mplier   <= b_mag;
                        acc      <= '0;
                        count    <= '0;
                        sign_q   <= a[WIDTH-1] ^ b[WIDTH-1];
                        round_q  <= round_mode;
                        sat_q    <= sat_en;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                    if (count == LAST) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    result    <= rs_result;
                    overflow  <= rs_overflow;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_multiplier_seq.sv
// Directed bench for fixed_multiplier_seq: a Q16.16 instance for the hand-computed
// vectors and an 8-bit Q4.4 instance checked against an integer reference model.
module tb_fixed_multiplier_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        in_valid, in_ready, round_mode, sat_en;
    logic        out_valid, out_ready, overflow, busy;
    logic [31:0] a, b, result;

    logic       in_valid8, in_ready8, round8, sat8;
    logic       out_valid8, out_ready8, overflow8, busy8;
    logic [7:0] a8, b8, result8;

    int checks = 0;
    int errors = 0;

    fixed_multiplier_seq #(.WIDTH(32), .FRAC(16)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .round_mode(round_mode), .sat_en(sat_en),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .overflow(overflow), .busy(busy)
    );

    fixed_multiplier_seq #(.WIDTH(8), .FRAC(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .round_mode(round8), .sat_en(sat8),
        .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
        .overflow(overflow8), .busy(busy8)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present operands for one cycle; later changes to every input must be ignored.
    task automatic start32(input logic [31:0] av, input logic [31:0] bv,
                           input logic rm, input logic se);
        @(negedge clk);
        a = av; b = bv; round_mode = rm; sat_en = se; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom; b = $urandom; round_mode = ~rm; sat_en = ~se;
    endtask

    // Returns the edge count from accept (accept edge = 1) to out_valid, 0 on timeout.
    task automatic wait32(output int lat);
        bit got;
        got = 1'b0;
        lat = 1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) got = 1'b1;
        end
        if (!got) lat = 0;
    endtask

    task automatic finish32();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic applyStimulus(input string tag, input logic [31:0] av,
                                 input logic [31:0] bv, input logic rm, input logic se,
                                 input logic [31:0] exp_r, input logic exp_o);
        int lat;
        start32(av, bv, rm, se);
        wait32(lat);
        checkOutput({tag, " latency"}, 64'(lat), 64'd34);
        checkOutput({tag, " result"}, 64'(result), 64'(exp_r));
        checkOutput({tag, " overflow"}, 64'(overflow), 64'(exp_o));
        finish32();
    endtask

    function automatic void model8(input logic [7:0] av, input logic [7:0] bv,
                                   input logic rm, input logic se,
                                   output logic [7:0] r, output logic o);
        int p;
        int s;
        p = int'($signed(av)) * int'($signed(bv));
        if (rm) p = p + 8;
        s = p >>> 4;
        o = (s > 127) || (s < -128);
        if (o && se) r = (s < 0) ? 8'h80 : 8'h7F;
        else         r = s[7:0];
    endfunction

    task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                        input logic rm, input logic se);
        int         lat;
        bit         got;
        logic [7:0] exp_r;
        logic       exp_o;
        @(negedge clk);
        a8 = av; b8 = bv; round8 = rm; sat8 = se; in_valid8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
        got = 1'b0;
        lat = 1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid8) got = 1'b1;
        end
        if (!got) lat = 0;
        model8(av, bv, rm, se, exp_r, exp_o);
        checkOutput($sformatf("w8 %02h*%02h m%0d s%0d latency", av, bv, rm, se), 64'(lat), 64'd10);
        checkOutput($sformatf("w8 %02h*%02h m%0d s%0d result", av, bv, rm, se), 64'(result8), 64'(exp_r));
        checkOutput($sformatf("w8 %02h*%02h m%0d s%0d overflow", av, bv, rm, se), 64'(overflow8), 64'(exp_o));
        out_ready8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready8 = 1'b0;
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; round_mode = 1'b0; sat_en = 1'b0;
        a = '0; b = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; round8 = 1'b0; sat8 = 1'b0;
        a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset result", 64'(result), 64'd0);
        checkOutput("reset overflow", 64'(overflow), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset w8 in_ready", 64'(in_ready8), 64'd1);
        rst_n = 1'b1;

        $display("[TB] basic products");
        applyStimulus("1.5*2.0", 32'h00018000, 32'h00020000, 1'b0, 1'b0, 32'h00030000, 1'b0);
        applyStimulus("-1.5*2.0", 32'hFFFE8000, 32'h00020000, 1'b0, 1'b0, 32'hFFFD0000, 1'b0);

        $display("[TB] overflow");
        applyStimulus("ovf sat", 32'h7FFF0000, 32'h00020000, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1);
        applyStimulus("ovf wrap", 32'h7FFF0000, 32'h00020000, 1'b0, 1'b0, 32'hFFFE0000, 1'b1);
        applyStimulus("min*min sat", 32'h80000000, 32'h80000000, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1);

        $display("[TB] rounding");
        applyStimulus("rnd pos trunc", 32'h00000001, 32'h00008000, 1'b0, 1'b0, 32'h00000000, 1'b0);
        applyStimulus("rnd pos half", 32'h00000001, 32'h00008000, 1'b1, 1'b0, 32'h00000001, 1'b0);
        applyStimulus("rnd neg trunc", 32'hFFFFFFFF, 32'h00008000, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0);
        applyStimulus("rnd neg half", 32'hFFFFFFFF, 32'h00008000, 1'b1, 1'b0, 32'h00000000, 1'b0);

        $display("[TB] handshake");
        start32(32'h00018000, 32'h00020000, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b1; a = 32'h00050000; b = 32'h00050000;
        checkOutput("hs calc in_ready", 64'(in_ready), 64'd0);
        checkOutput("hs calc busy", 64'(busy), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait32(lat);
        checkOutput("hs out_valid seen", 64'(lat != 0), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("hs hold%0d result", i), 64'(result), 64'h00030000);
            checkOutput($sformatf("hs hold%0d out_valid", i), 64'(out_valid), 64'd1);
            checkOutput($sformatf("hs hold%0d in_ready", i), 64'(in_ready), 64'd0);
        end
        finish32();
        checkOutput("hs release in_ready", 64'(in_ready), 64'd1);
        checkOutput("hs release out_valid", 64'(out_valid), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("hs no capture busy", 64'(busy), 64'd0);

        $display("[TB] reset during CALC");
        start32(32'h7FFF0000, 32'h00020000, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midrst in_ready", 64'(in_ready), 64'd1);
        checkOutput("midrst out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst result", 64'(result), 64'd0);
        checkOutput("midrst busy", 64'(busy), 64'd0);
        applyStimulus("post-reset 1.5*2.0", 32'h00018000, 32'h00020000, 1'b0, 1'b0, 32'h00030000, 1'b0);

        $display("[TB] 8-bit sweep");
        for (int m = 0; m < 4; m++) begin
            run8(8'h80, 8'h80, m[0], m[1]);
            run8(8'h7F, 8'h81, m[0], m[1]);
        end
        for (int i = 0; i < 24; i++) begin
            run8(8'($urandom), 8'($urandom), i[0], i[1]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
